// File: rtl/rf_blk_mv_if.sv
// Command-side interface of the block-move engine: the master issues a move
// command and observes busy/done/err status.
interface rf_blk_mv_if #(
   parameter int ADDR_W = 9,
   parameter int LEN_W  = 10
);
   logic              mv_start;
   logic              mv_mode;
   logic [ADDR_W-1:0] src_addr;
   logic [ADDR_W-1:0] dst_addr;
   logic [LEN_W-1:0]  mv_len;
   logic              mv_busy;
   logic              mv_done;
   logic              mv_err;

   modport master (
      output mv_start, mv_mode, src_addr, dst_addr, mv_len,
      input  mv_busy, mv_done, mv_err
   );

   modport slave (
      input  mv_start, mv_mode, src_addr, dst_addr, mv_len,
      output mv_busy, mv_done, mv_err
   );
endinterface

// File: rtl/rf_blk_mv.sv
// Block-move engine for the single-port RF RAM: copies (memmove semantics) or
// swaps a run of consecutive rows between two address ranges.
module rf_blk_mv #(
   parameter int WIDTH  = 1408,
   parameter int ADDR_W = 9,
   parameter int LEN_W  = 10
) (
   input  logic              clk,
   input  logic              rst,
   rf_blk_mv_if.slave        mv,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_re,
   output logic              ram_we,
   output logic [WIDTH-1:0]  ram_d,
   input  logic [WIDTH-1:0]  ram_q
);

   localparam int CW = (ADDR_W + 1 > LEN_W) ? ADDR_W + 1 : LEN_W;

   typedef enum logic [3:0] {
      IDLE, RD, LD, WR, RDA, RDB, LDB, WRA, WRB
   } state_t;

   state_t            state;
   state_t            next_state;
   logic [ADDR_W-1:0] src_r;
   logic [ADDR_W-1:0] dst_r;
   logic [LEN_W-1:0]  len_r;
   logic [LEN_W-1:0]  idx;
   logic              desc_r;
   logic              busy_r;
   logic              done_r;
   logic              err_r;
   logic [WIDTH-1:0]  buf_a;
   logic [WIDTH-1:0]  buf_b;

   logic [ADDR_W-1:0] off;
   logic [CW-1:0]     off_w;
   logic [CW-1:0]     off_rev;
   logic [CW-1:0]     len_w;
   logic              swap_bad;
   logic              fwd_overlap;
   logic              accept;
   logic              last_row;
   logic              row_end;
   logic              re_int;
   logic              we_int;
   logic              use_dst;

   // Overlap is judged on the wrapped distance from range A to range B.
   assign accept      = mv.mv_start && !busy_r;
   assign off         = mv.dst_addr - mv.src_addr;
   assign off_w       = CW'(off);
   assign off_rev     = (CW'(1) << ADDR_W) - off_w;
   assign len_w       = CW'(mv.mv_len);
   assign swap_bad    = (off_w < len_w) || (off_rev < len_w);
   assign fwd_overlap = (off != '0) && (off_w < len_w);
   assign last_row    = desc_r ? (idx == '0) : (idx == len_r - LEN_W'(1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      re_int     = 1'b0;
      we_int     = 1'b0;
      use_dst    = 1'b0;
      row_end    = 1'b0;
      case (state)
         IDLE: begin
            if (accept && (mv.mv_len != '0) && !(mv.mv_mode && swap_bad)) begin
               next_state = mv.mv_mode ? RDA : RD;
            end
         end
         RD: begin
            re_int     = 1'b1;
            next_state = LD;
         end
         LD: next_state = WR;
         WR: begin
            we_int     = 1'b1;
            use_dst    = 1'b1;
            row_end    = 1'b1;
            next_state = last_row ? IDLE : RD;
         end
         RDA: begin
            re_int     = 1'b1;
            next_state = RDB;
         end
         RDB: begin
            re_int     = 1'b1;
            use_dst    = 1'b1;
            next_state = LDB;
         end
         LDB: next_state = WRA;
         WRA: begin
            we_int     = 1'b1;
            next_state = WRB;
         end
         WRB: begin
            we_int     = 1'b1;
            use_dst    = 1'b1;
            row_end    = 1'b1;
            next_state = last_row ? IDLE : RDA;
         end
         default: next_state = IDLE;
      endcase
   end

   // Enables are gated by reset so a mid-command reset never touches the RAM.
   assign ram_re   = re_int & ~rst;
   assign ram_we   = we_int & ~rst;
   assign ram_addr = (use_dst ? dst_r : src_r) + ADDR_W'(idx);
   assign ram_d    = (state == WRA) ? buf_b : buf_a;

   always_ff @(posedge clk) begin
      if (rst) begin
         src_r  <= '0;
         dst_r  <= '0;
         len_r  <= '0;
         idx    <= '0;
         desc_r <= 1'b0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
         err_r  <= 1'b0;
         buf_a  <= '0;
         buf_b  <= '0;
      end else begin
         if (state == IDLE && accept) begin
            src_r  <= mv.src_addr;
            dst_r  <= mv.dst_addr;
            len_r  <= mv.mv_len;
            desc_r <= !mv.mv_mode && fwd_overlap;
            idx    <= (!mv.mv_mode && fwd_overlap) ? mv.mv_len - LEN_W'(1) : '0;
            if (mv.mv_len == '0) begin
               done_r <= 1'b1;
               err_r  <= 1'b0;
            end else if (mv.mv_mode && swap_bad) begin
               done_r <= 1'b1;
               err_r  <= 1'b1;
            end else begin
               busy_r <= 1'b1;
               done_r <= 1'b0;
               err_r  <= 1'b0;
            end
         end
         case (state)
            LD, RDB: buf_a <= ram_q;
            LDB:     buf_b <= ram_q;
            default: ;
         endcase
         if (row_end) begin
            if (last_row) begin
               busy_r <= 1'b0;
               done_r <= 1'b1;
            end else begin
               idx <= desc_r ? idx - LEN_W'(1) : idx + LEN_W'(1);
            end
         end
      end
   end

   assign mv.mv_busy = busy_r;
   assign mv.mv_done = done_r;
   assign mv.mv_err  = err_r;

endmodule

// File: tb/tb_rf_blk_mv.sv
// Self-checking bench for rf_blk_mv: table-driven spec cases, hand-written
// corner sequences and randomized commands against a snapshot-based memory model.
module tb_rf_blk_mv;

   localparam int WIDTH  = 1408;
   localparam int ADDR_W = 9;
   localparam int LEN_W  = 10;
   localparam int DEPTH  = 512;

   typedef struct {
      logic mode;
      int   src;
      int   dst;
      int   len;
      logic exp_err;
      int   exp_cycles;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   rf_blk_mv_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) mv ();

   logic [ADDR_W-1:0] ram_addr;
   logic              ram_re;
   logic              ram_we;
   logic [WIDTH-1:0]  ram_d;
   logic [WIDTH-1:0]  ram_q;

   rf_blk_mv #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .mv       (mv),
      .ram_addr (ram_addr),
      .ram_re   (ram_re),
      .ram_we   (ram_we),
      .ram_d    (ram_d),
      .ram_q    (ram_q)
   );

   // RAM with 1-cycle read latency, plus an access log for order checks.
   logic [WIDTH-1:0]  mem [DEPTH];
   logic              pre_we;
   logic [ADDR_W-1:0] pre_addr;
   logic [WIDTH-1:0]  pre_d;
   int                rd_log[$];
   int                wr_log[$];
   int                clash = 0;

   always @(posedge clk) begin
      if (pre_we) mem[pre_addr] <= pre_d;
      else if (ram_we) mem[ram_addr] <= ram_d;
      if (ram_re) ram_q <= mem[ram_addr];
      if (ram_re) rd_log.push_back(int'(ram_addr));
      if (ram_we) wr_log.push_back(int'(ram_addr));
      if (ram_re && ram_we) clash <= clash + 1;
   end

   logic [WIDTH-1:0] ref_mem [DEPTH];
   int               exp_rd[$];
   int               exp_wr[$];
   logic             m_err;
   int               m_cycles;
   logic             got_err;
   int               got_cycles;
   int               checks   = 0;
   int               failures = 0;

   task automatic check(input string name, input longint actual, input longint expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
      end
   endtask

   function automatic logic [WIDTH-1:0] rand_row();
      logic [WIDTH-1:0] r;
      for (int i = 0; i < WIDTH / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic check_mem(input string tag);
      int bad = 0;
      for (int a = 0; a < DEPTH; a++) if (mem[a] !== ref_mem[a]) bad++;
      check({tag, "_mem_rows_wrong"}, bad, 0);
   endtask

   // Reference: whole-block snapshots give memmove/exchange results directly.
   task automatic model_cmd(input logic mode, input int src, input int dst, input int len);
      logic [WIDTH-1:0] snap_a[$];
      logic [WIDTH-1:0] snap_b[$];
      int off, a, b, i;
      exp_rd.delete();
      exp_wr.delete();
      off      = (((dst - src) % DEPTH) + DEPTH) % DEPTH;
      m_err    = 1'b0;
      m_cycles = 1;
      if (len == 0) return;
      if (mode) begin
         if (off < len || (DEPTH - off) < len) begin
            m_err = 1'b1;
            return;
         end
         m_cycles = 1 + 5 * len;
         for (int k = 0; k < len; k++) begin
            a = (src + k) % DEPTH;
            b = (dst + k) % DEPTH;
            exp_rd.push_back(a); exp_rd.push_back(b);
            exp_wr.push_back(a); exp_wr.push_back(b);
            snap_a.push_back(ref_mem[a]);
            snap_b.push_back(ref_mem[b]);
         end
         for (int k = 0; k < len; k++) begin
            ref_mem[(src + k) % DEPTH] = snap_b[k];
            ref_mem[(dst + k) % DEPTH] = snap_a[k];
         end
      end else begin
         m_cycles = 1 + 3 * len;
         for (int k = 0; k < len; k++) snap_a.push_back(ref_mem[(src + k) % DEPTH]);
         for (int k = 0; k < len; k++) ref_mem[(dst + k) % DEPTH] = snap_a[k];
         for (int k = 0; k < len; k++) begin
            i = (off > 0 && off < len) ? len - 1 - k : k;
            exp_rd.push_back((src + i) % DEPTH);
            exp_wr.push_back((dst + i) % DEPTH);
         end
      end
   endtask

   // Issues one command at the current negedge; poke_cycle>0 fires a stray start while busy.
   task automatic apply_stimulus(input string tag, input logic mode, input int src, input int dst,
                                 input int len, input int poke_cycle);
      int rd_base, wr_base, cycles, bad;
      rd_base = rd_log.size();
      wr_base = wr_log.size();
      model_cmd(mode, src, dst, len);
      mv.mv_start = 1'b1;
      mv.mv_mode  = mode;
      mv.src_addr = ADDR_W'(src);
      mv.dst_addr = ADDR_W'(dst);
      mv.mv_len   = LEN_W'(len);
      @(negedge clk);
      mv.mv_start = 1'b0;
      cycles      = 1;
      if (len != 0 && !m_err) begin
         check({tag, "_busy_at_1"}, mv.mv_busy, 1);
         check({tag, "_done_clr"}, mv.mv_done, 0);
      end
      while (!mv.mv_done && cycles < 200) begin
         if (cycles == poke_cycle) begin
            mv.mv_start = 1'b1;
            mv.mv_mode  = 1'b1;
            mv.src_addr = ADDR_W'(src + 1);
            mv.dst_addr = ADDR_W'(dst + 100);
            mv.mv_len   = LEN_W'(1);
         end
         @(negedge clk);
         mv.mv_start = 1'b0;
         cycles++;
      end
      got_err    = mv.mv_err;
      got_cycles = cycles;
      check_output(tag, rd_base, wr_base);
   endtask

   task automatic check_output(input string tag, input int rd_base, input int wr_base);
      int bad;
      check({tag, "_done"}, mv.mv_done, 1);
      check({tag, "_busy_end"}, mv.mv_busy, 0);
      check({tag, "_err"}, got_err, m_err);
      check({tag, "_cycles"}, got_cycles, m_cycles);
      check({tag, "_re_count"}, rd_log.size() - rd_base, exp_rd.size());
      check({tag, "_we_count"}, wr_log.size() - wr_base, exp_wr.size());
      bad = 0;
      for (int i = 0; i < exp_rd.size(); i++)
         if (rd_base + i >= rd_log.size() || rd_log[rd_base + i] != exp_rd[i]) bad++;
      check({tag, "_rd_order_bad"}, bad, 0);
      bad = 0;
      for (int i = 0; i < exp_wr.size(); i++)
         if (wr_base + i >= wr_log.size() || wr_log[wr_base + i] != exp_wr[i]) bad++;
      check({tag, "_wr_order_bad"}, bad, 0);
      check_mem(tag);
   endtask

   vec_t vecs[12];

   initial begin
      vecs[0]  = '{1'b0,  10, 100, 4, 1'b0, 13};
      vecs[1]  = '{1'b0,  20,  22, 4, 1'b0, 13};
      vecs[2]  = '{1'b0,  22,  20, 4, 1'b0, 13};
      vecs[3]  = '{1'b1,   0,  50, 2, 1'b0, 11};
      vecs[4]  = '{1'b1,   5,   6, 2, 1'b1,  1};
      vecs[5]  = '{1'b0,  30,  40, 0, 1'b0,  1};
      vecs[6]  = '{1'b0, 510,   0, 3, 1'b0, 10};
      vecs[7]  = '{1'b1,   5,   5, 1, 1'b1,  1};
      vecs[8]  = '{1'b0,   7,   7, 2, 1'b0,  7};
      vecs[9]  = '{1'b1, 100,  97, 3, 1'b0, 16};
      vecs[10] = '{1'b1, 100, 103, 3, 1'b0, 16};
      vecs[11] = '{1'b1, 100, 102, 3, 1'b1,  1};

      rst         = 1'b1;
      pre_we      = 1'b0;
      pre_addr    = '0;
      pre_d       = '0;
      mv.mv_start = 1'b0;
      mv.mv_mode  = 1'b0;
      mv.src_addr = '0;
      mv.dst_addr = '0;
      mv.mv_len   = '0;
      @(negedge clk);
      @(negedge clk);
      for (int a = 0; a < DEPTH; a++) begin
         pre_we      = 1'b1;
         pre_addr    = ADDR_W'(a);
         pre_d       = rand_row();
         ref_mem[a]  = pre_d;
         @(negedge clk);
      end
      pre_we = 1'b0;
      check("rst_busy", mv.mv_busy, 0);
      check("rst_done", mv.mv_done, 0);
      check("rst_err", mv.mv_err, 0);
      check("rst_re", ram_re, 0);
      check("rst_we", ram_we, 0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_busy", mv.mv_busy, 0);
      check("idle_re_we", {ram_re, ram_we}, 0);

      for (int i = 0; i < 12; i++) begin
         apply_stimulus($sformatf("vec%0d", i), vecs[i].mode, vecs[i].src, vecs[i].dst,
                        vecs[i].len, -1);
         check($sformatf("vec%0d_tbl_err", i), got_err, vecs[i].exp_err);
         check($sformatf("vec%0d_tbl_cycles", i), got_cycles, vecs[i].exp_cycles);
      end

      apply_stimulus("busy_ignore", 1'b0, 400, 450, 2, 2);
      @(negedge clk);
      check("busy_ignore_not_queued", mv.mv_busy, 0);

      // Reset during row 2's read of a 5-row copy: rows 0 and 1 stay written.
      ref_mem[300] = ref_mem[200];
      ref_mem[301] = ref_mem[201];
      mv.mv_start = 1'b1;
      mv.mv_mode  = 1'b0;
      mv.src_addr = ADDR_W'(200);
      mv.dst_addr = ADDR_W'(300);
      mv.mv_len   = LEN_W'(5);
      @(negedge clk);
      mv.mv_start = 1'b0;
      repeat (6) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_re", ram_re, 0);
      check("midrst_we", ram_we, 0);
      @(negedge clk);
      rst = 1'b0;
      check("midrst_busy", mv.mv_busy, 0);
      check("midrst_done", mv.mv_done, 0);
      check_mem("midrst");
      apply_stimulus("after_rst", 1'b1, 300, 310, 3, -1);

      for (int n = 0; n < 25; n++) begin
         logic m;
         int   s, d, l;
         m = 1'($urandom_range(0, 1));
         s = int'($urandom_range(0, DEPTH - 1));
         case ($urandom_range(0, 2))
            0:       d = int'($urandom_range(0, DEPTH - 1));
            1:       d = (s + int'($urandom_range(0, 7))) % DEPTH;
            default: d = (s + DEPTH - int'($urandom_range(0, 7))) % DEPTH;
         endcase
         l = int'($urandom_range(0, 6));
         apply_stimulus($sformatf("rnd%0d", n), m, s, d, l, -1);
      end

      check("re_we_clash", clash, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
